instruction_fetch: RTL and testbench

- IF stage of the 5-stage MIPS pipeline, directly upstream of the decode stage.
- Holds the PC and a word-addressed instruction memory that the debug unit loads over a write port.
- Selects the next PC from sequential, branch, jump and jump-register sources, and drives the IF/ID register (PC+4, instruction) consumed by decode.
- Handles stall, branch flush and HALT detection.

---
 rtl/instruction_fetch.sv | 97 +++++++++
 tb/tb_instruction_fetch.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// IF stage: PC, debug-loadable word memory, next-PC select, IF/ID register. Optional macro IFETCH_BOUNDS_EN.
// Latency: one cycle from PC to out_instruction/out_pc_branch.
// Backpressure: stall holds PC and IF/ID, enable=0 freezes all; memory writes proceed regardless.
module instruction_fetch #(
    parameter int                len         = 32,
    parameter int                NB_ADDR     = 10,
    parameter logic [len-1:0]    HALT_OPCODE = 32'hFFFFFFFF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 stall,
    input  logic                 branch_taken,
    input  logic [len-1:0]       in_pc_branch,
    input  logic                 flag_jump,
    input  logic [len-1:0]       in_pc_jump,
    input  logic                 flag_jump_register,
    input  logic [len-1:0]       in_pc_jump_register,
    input  logic                 prog_we,
    input  logic [NB_ADDR-1:0]   prog_addr,
    input  logic [len-1:0]       prog_data,
    output logic [len-1:0]       out_pc,
    output logic [len-1:0]       out_pc_branch,
    output logic [len-1:0]       out_instruction,
    output logic                 out_halt_flag
);

    logic [len-1:0]     r_mem [0:(1<<NB_ADDR)-1];
    logic [len-1:0]     r_pc;
    logic [len-1:0]     r_pc_branch;
    logic [len-1:0]     r_instruction;
    logic               r_halt;

    logic [NB_ADDR-1:0] w_fetch_idx;
    logic [len-1:0]     w_fetch_word;
    logic [len-1:0]     w_pc_plus4;
    logic               w_is_halt;

    assign w_fetch_idx  = r_pc[NB_ADDR+1:2];
    assign w_fetch_word = r_mem[w_fetch_idx];
    assign w_pc_plus4   = r_pc + len'(4);

`ifdef IFETCH_BOUNDS_EN
    // A PC beyond the memory is fatal: treat it like a fetched HALT.
    logic w_out_of_bounds;
    assign w_out_of_bounds = |r_pc[len-1:NB_ADDR+2];
    assign w_is_halt       = (w_fetch_word == HALT_OPCODE) || w_out_of_bounds;
`else
    assign w_is_halt       = (w_fetch_word == HALT_OPCODE);
`endif

    always_ff @(posedge clk) begin
        if (prog_we)
            r_mem[prog_addr] <= prog_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= '0;
            r_pc_branch   <= '0;
            r_instruction <= '0;
            r_halt        <= 1'b0;
        end else if (enable) begin
            if (r_halt) begin
                r_pc          <= r_pc;
            end else if (branch_taken) begin
                // Branch beats stall: the stalled instruction is on the wrong path.
                r_pc          <= in_pc_branch;
                r_pc_branch   <= '0;
                r_instruction <= '0;
            end else if (stall) begin
                r_pc          <= r_pc;
            end else if (flag_jump_register) begin
                r_pc          <= in_pc_jump_register;
                r_pc_branch   <= w_pc_plus4;
                r_instruction <= '0;
            end else if (flag_jump) begin
                r_pc          <= in_pc_jump;
                r_pc_branch   <= w_pc_plus4;
                r_instruction <= '0;
            end else if (w_is_halt) begin
                r_halt        <= 1'b1;
                r_instruction <= '0;
            end else begin
                r_pc          <= w_pc_plus4;
                r_pc_branch   <= w_pc_plus4;
                r_instruction <= w_fetch_word;
            end
        end
    end

    assign out_pc          = r_pc;
    assign out_pc_branch   = r_pc_branch;
    assign out_instruction = r_instruction;
    assign out_halt_flag   = r_halt;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: vector table driven cycle by cycle, expectations queued and popped after each edge.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        reset, enable, stall, branch_taken, flag_jump, flag_jump_register, prog_we;
    logic [31:0] in_pc_branch, in_pc_jump, in_pc_jump_register, prog_data;
    logic [9:0]  prog_addr;
    logic [31:0] out_pc, out_pc_branch, out_instruction;
    logic        out_halt_flag;

    always #5 clk = ~clk;

    instruction_fetch dut (
        .clk                 (clk),
        .reset               (reset),
        .enable              (enable),
        .stall               (stall),
        .branch_taken        (branch_taken),
        .in_pc_branch        (in_pc_branch),
        .flag_jump           (flag_jump),
        .in_pc_jump          (in_pc_jump),
        .flag_jump_register  (flag_jump_register),
        .in_pc_jump_register (in_pc_jump_register),
        .prog_we             (prog_we),
        .prog_addr           (prog_addr),
        .prog_data           (prog_data),
        .out_pc              (out_pc),
        .out_pc_branch       (out_pc_branch),
        .out_instruction     (out_instruction),
        .out_halt_flag       (out_halt_flag)
    );

    typedef struct {
        logic        rst, en, st, br;
        logic [31:0] pbr;
        logic        j;
        logic [31:0] pj;
        logic        jr;
        logic [31:0] pjr;
        logic        we;
        logic [9:0]  wa;
        logic [31:0] wd;
        logic [31:0] e_pc, e_pcb, e_ins;
        logic        e_halt, ck_pcb;
    } vec_t;

    typedef struct {
        logic [31:0] pc, pcb, ins;
        logic        halt, ck_pcb;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_pass = 0;
    int   n_total = 0;

    function automatic logic [31:0] W(input int i);
        if (i == 0) return 32'h20010005;
        if (i == 1) return 32'h20020007;
        if (i == 2) return 32'hFFFFFFFF;
        return 32'hC0DE0000 | 32'(i);
    endfunction

    function automatic vec_t mk(input logic rst, en, st, br, input logic [31:0] pbr,
                                input logic j, input logic [31:0] pj,
                                input logic jr, input logic [31:0] pjr,
                                input logic we, input logic [9:0] wa, input logic [31:0] wd,
                                input logic [31:0] epc, epcb, eins, input logic eh, ck);
        vec_t v;
        v.rst = rst; v.en = en; v.st = st; v.br = br; v.pbr = pbr;
        v.j = j; v.pj = pj; v.jr = jr; v.pjr = pjr;
        v.we = we; v.wa = wa; v.wd = wd;
        v.e_pc = epc; v.e_pcb = epcb; v.e_ins = eins; v.e_halt = eh; v.ck_pcb = ck;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    task automatic drive(input vec_t v);
        reset = v.rst; enable = v.en; stall = v.st; branch_taken = v.br; in_pc_branch = v.pbr;
        flag_jump = v.j; in_pc_jump = v.pj; flag_jump_register = v.jr; in_pc_jump_register = v.pjr;
        prog_we = v.we; prog_addr = v.wa; prog_data = v.wd;
    endtask

    initial begin
        exp_t e;
        // Load memory while held in reset; writes do not depend on enable.
        drive(mk(1,0,0,0,0, 0,0, 0,0, 0,0,0, 0,0,0,0,1));
        for (int i = 0; i < 32; i++) begin
            prog_we = 1'b1; prog_addr = 10'(i); prog_data = W(i);
            @(posedge clk); #1;
        end
        prog_we = 1'b1; prog_addr = 10'd1023; prog_data = W(1023);
        @(posedge clk); #1;
        prog_we = 1'b0;
        @(posedge clk); #1;
        chk("reset pc",   out_pc,              32'h0);
        chk("reset pcb",  out_pc_branch,       32'h0);
        chk("reset ins",  out_instruction,     32'h0);
        chk("reset halt", {31'b0, out_halt_flag}, 32'h0);

        //            rst en st br pbr            j  pj            jr pjr    we wa  wd          e_pc          e_pcb         e_ins         eh ck
        vecs.push_back(mk(0,1,0,0,0,            0,0,            0,0,     0,0,0,             32'h4,        32'h4,        W(0),         0,1));
        vecs.push_back(mk(0,1,0,0,0,            0,0,            0,0,     0,0,0,             32'h8,        32'h8,        W(1),         0,1));
        vecs.push_back(mk(0,1,0,0,0,            0,0,            0,0,     0,0,0,             32'h8,        32'h0,        32'h0,        1,0));
        vecs.push_back(mk(0,1,0,1,32'h40,       1,32'h50,       0,0,     0,0,0,             32'h8,        32'h0,        32'h0,        1,0));
        vecs.push_back(mk(1,1,1,0,0,            1,32'h50,       0,0,     0,0,0,             32'h0,        32'h0,        32'h0,        0,1));
        vecs.push_back(mk(0,1,0,0,0,            1,32'hC,        0,0,     0,0,0,             32'hC,        32'h4,        32'h0,        0,1));
        vecs.push_back(mk(0,1,0,0,0,            0,0,            0,0,     0,0,0,             32'h10,       32'h10,       W(3),         0,1));
        vecs.push_back(mk(0,1,0,1,32'h40,       0,0,            0,0,     0,0,0,             32'h40,       32'h0,        32'h0,        0,1));
        vecs.push_back(mk(0,1,0,0,0,            0,0,            0,0,     0,0,0,             32'h44,       32'h44,       W(16),        0,1));
        vecs.push_back(mk(0,1,0,0,0,            1,32'h50,       1,32'h30,0,0,0,             32'h30,       32'h48,       32'h0,        0,1));
        vecs.push_back(mk(0,1,1,1,32'h20,       0,0,            0,0,     0,0,0,             32'h20,       32'h0,        32'h0,        0,1));
        vecs.push_back(mk(0,1,0,0,0,            0,0,            0,0,     0,0,0,             32'h24,       32'h24,       W(8),         0,1));
        vecs.push_back(mk(0,1,1,0,0,            0,0,            0,0,     0,0,0,             32'h24,       32'h24,       W(8),         0,1));
        vecs.push_back(mk(0,1,1,0,0,            1,32'h50,       0,0,     0,0,0,             32'h24,       32'h24,       W(8),         0,1));
        vecs.push_back(mk(0,1,0,0,0,            0,0,            0,0,     0,0,0,             32'h28,       32'h28,       W(9),         0,1));
        vecs.push_back(mk(0,0,0,1,32'h40,       0,0,            0,0,     1,5,32'h1234,      32'h28,       32'h28,       W(9),         0,1));
        vecs.push_back(mk(0,0,1,0,0,            1,32'h50,       0,0,     0,0,0,             32'h28,       32'h28,       W(9),         0,1));
        vecs.push_back(mk(0,0,0,0,0,            0,0,            1,32'h70,0,0,0,             32'h28,       32'h28,       W(9),         0,1));
        vecs.push_back(mk(0,1,0,0,0,            1,32'h14,       0,0,     0,0,0,             32'h14,       32'h2C,       32'h0,        0,1));
        vecs.push_back(mk(0,1,0,0,0,            0,0,            0,0,     0,0,0,             32'h18,       32'h18,       32'h1234,     0,1));
        vecs.push_back(mk(0,0,0,0,0,            0,0,            0,0,     1,6,32'hBEEF,      32'h18,       32'h18,       32'h1234,     0,1));
        vecs.push_back(mk(0,1,0,0,0,            0,0,            0,0,     0,0,0,             32'h1C,       32'h1C,       32'hBEEF,     0,1));
        vecs.push_back(mk(0,1,0,0,0,            1,32'h100C,     0,0,     0,0,0,             32'h100C,     32'h20,       32'h0,        0,1));
`ifdef IFETCH_BOUNDS_EN
        vecs.push_back(mk(0,1,0,0,0,            0,0,            0,0,     0,0,0,             32'h100C,     32'h0,        32'h0,        1,0));
`else
        vecs.push_back(mk(0,1,0,0,0,            0,0,            0,0,     0,0,0,             32'h1010,     32'h1010,     W(3),         0,1));
        vecs.push_back(mk(0,1,0,0,0,            1,32'hFFFFFFFC, 0,0,     0,0,0,             32'hFFFFFFFC, 32'h1014,     32'h0,        0,1));
        vecs.push_back(mk(0,1,0,0,0,            0,0,            0,0,     0,0,0,             32'h0,        32'h0,        W(1023),      0,1));
`endif
        vecs.push_back(mk(1,1,1,0,0,            0,0,            0,0,     0,0,0,             32'h0,        32'h0,        32'h0,        0,1));
        vecs.push_back(mk(0,1,0,0,0,            0,0,            0,0,     0,0,0,             32'h4,        32'h4,        W(0),         0,1));

        foreach (vecs[i]) begin
            drive(vecs[i]);
            sb.push_back('{pc: vecs[i].e_pc, pcb: vecs[i].e_pcb, ins: vecs[i].e_ins,
                           halt: vecs[i].e_halt, ck_pcb: vecs[i].ck_pcb});
            @(posedge clk); #1;
            e = sb.pop_front();
            chk($sformatf("v%0d pc", i),   out_pc,          e.pc);
            chk($sformatf("v%0d ins", i),  out_instruction, e.ins);
            chk($sformatf("v%0d halt", i), {31'b0, out_halt_flag}, {31'b0, e.halt});
            if (e.ck_pcb)
                chk($sformatf("v%0d pcb", i), out_pc_branch, e.pcb);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
